// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
// decoder_pkg : shared types and the one-hot helper for onehot_decoder_seq
// Revision    : 1.0
// ============================================================================
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'd0,
        MODE_SCAN_UP   = 2'd1,
        MODE_SCAN_DOWN = 2'd2,
        MODE_HOLD      = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DIRECT    = 3'd1,
        ST_SCAN_UP   = 3'd2,
        ST_SCAN_DOWN = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    // Widest code the helper supports; callers truncate to their own 2**N.
    localparam int ONEHOT_MAX_N = 8;

    function automatic logic [(1 << ONEHOT_MAX_N)-1:0] onehot(
        input logic [ONEHOT_MAX_N-1:0] code
    );
        logic [(1 << ONEHOT_MAX_N)-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/onehot_decoder_seq_dwell_counter.sv
`default_nettype none
// ============================================================================
// dwell_counter : counts cycles an index is held; tick marks the last one
// Revision      : 1.0
// ============================================================================
module dwell_counter #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int DW = $clog2(DWELL + 1);

    logic [DW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == DW'(DWELL - 1));
    assign tick   = run && w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= w_last ? '0 : r_count + DW'(1);
        end
    end

endmodule : dwell_counter
`default_nettype wire

// File: rtl/onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// onehot_decoder_seq : registered one-hot select driven directly or by a scan
// Revision           : 1.0
// ============================================================================
module onehot_decoder_seq
    import decoder_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [N-1:0]      x,
    input  logic              load,
    output logic [2**N-1:0]   w,
    output logic [N-1:0]      idx,
    output logic              wrap,
    output logic              active
);

    localparam int           c_W       = 1 << N;
    localparam logic [N-1:0] c_IDX_MAX = '1;

    state_t         r_state;
    logic [N-1:0]   r_idx;
    logic [c_W-1:0] r_w;
    logic           r_wrap;
    logic           r_active;

    state_t         w_nstate;
    logic           w_state_chg;
    logic           w_scan;
    logic           w_run;
    logic           w_clr;
    logic           w_tick;
    logic           w_at_edge;
    logic [N-1:0]   w_idx_nxt;
    logic           w_wrap_nxt;
    logic [c_W-1:0] w_onehot;

    // The state is chosen from this cycle's inputs, so every action applies at
    // the very edge the mode is presented (one-cycle latency x -> w).
    always_comb begin
        w_nstate = ST_IDLE;
        if (en) begin
            case (mode_t'(mode))
                MODE_DIRECT:    w_nstate = ST_DIRECT;
                MODE_SCAN_UP:   w_nstate = ST_SCAN_UP;
                MODE_SCAN_DOWN: w_nstate = ST_SCAN_DOWN;
                MODE_HOLD:      w_nstate = ST_HOLD;
                default:        w_nstate = ST_IDLE;
            endcase
        end
    end

    assign w_state_chg = (w_nstate != r_state);
    assign w_scan      = (w_nstate == ST_SCAN_UP) || (w_nstate == ST_SCAN_DOWN);
    // A state change or a load restarts the dwell without stepping.
    assign w_run       = w_scan && !load && !w_state_chg;
    assign w_clr       = !w_run && !((w_nstate == ST_HOLD) && !w_state_chg);
    assign w_at_edge   = (w_nstate == ST_SCAN_UP) ? (r_idx == c_IDX_MAX)
                                                  : (r_idx == '0);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .run   (w_run),
        .tick  (w_tick)
    );

    always_comb begin
        w_idx_nxt = r_idx;
        case (w_nstate)
            ST_DIRECT:    w_idx_nxt = x;
            ST_SCAN_UP:   w_idx_nxt = load ? x : (w_tick ? r_idx + 1'b1 : r_idx);
            ST_SCAN_DOWN: w_idx_nxt = load ? x : (w_tick ? r_idx - 1'b1 : r_idx);
            default:      w_idx_nxt = r_idx;
        endcase
    end

    assign w_wrap_nxt = w_tick && w_at_edge;
    assign w_onehot   = c_W'(onehot(ONEHOT_MAX_N'(w_idx_nxt)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_w      <= '0;
            r_wrap   <= 1'b0;
            r_active <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_idx   <= w_idx_nxt;
            r_wrap  <= w_wrap_nxt;
            if (w_nstate == ST_IDLE) begin
                r_w      <= '0;
                r_active <= 1'b0;
            end else begin
                r_w      <= w_onehot;
                r_active <= 1'b1;
            end
        end
    end

    assign w      = r_w;
    assign idx    = r_idx;
    assign wrap   = r_wrap;
    assign active = r_active;

endmodule : onehot_decoder_seq
`default_nettype wire

// File: tb/tb_onehot_decoder_seq.sv
`default_nettype none
// ============================================================================
// tb_onehot_decoder_seq : directed self-checking bench, three parameter sets
// Revision              : 1.0
// ============================================================================
module tb_onehot_decoder_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // A: N=3 DWELL=1
    logic       a_rst_n, a_en, a_load;
    logic [1:0] a_mode;
    logic [2:0] a_x, a_idx;
    logic [7:0] a_w;
    logic       a_wrap, a_active;
    // B: N=3 DWELL=3
    logic       b_rst_n, b_en, b_load;
    logic [1:0] b_mode;
    logic [2:0] b_x, b_idx;
    logic [7:0] b_w;
    logic       b_wrap, b_active;
    // C: N=4 DWELL=2
    logic        c_rst_n, c_en, c_load;
    logic [1:0]  c_mode;
    logic [3:0]  c_x, c_idx;
    logic [15:0] c_w;
    logic        c_wrap, c_active;

    onehot_decoder_seq #(.N(3), .DWELL(1)) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .en(a_en), .mode(a_mode), .x(a_x), .load(a_load),
        .w(a_w), .idx(a_idx), .wrap(a_wrap), .active(a_active));

    onehot_decoder_seq #(.N(3), .DWELL(3)) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .en(b_en), .mode(b_mode), .x(b_x), .load(b_load),
        .w(b_w), .idx(b_idx), .wrap(b_wrap), .active(b_active));

    onehot_decoder_seq #(.N(4), .DWELL(2)) u_dut_c (
        .clk(clk), .rst_n(c_rst_n), .en(c_en), .mode(c_mode), .x(c_x), .load(c_load),
        .w(c_w), .idx(c_idx), .wrap(c_wrap), .active(c_active));

    task automatic test_reset();
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        a_en = 1'b0; a_mode = 2'd0; a_x = '0; a_load = 1'b0;
        b_en = 1'b0; b_mode = 2'd0; b_x = '0; b_load = 1'b0;
        c_en = 1'b0; c_mode = 2'd0; c_x = '0; c_load = 1'b0;
        #1;
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        #11;
        n_vec++;
        if ({a_w, a_idx, a_wrap, a_active} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_a: w=%h idx=%0d wrap=%b active=%b, want all 0", a_w, a_idx, a_wrap, a_active);
        end
        n_vec++;
        if ({b_w, b_idx, b_wrap, b_active} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_b: w=%h idx=%0d wrap=%b active=%b, want all 0", b_w, b_idx, b_wrap, b_active);
        end
        n_vec++;
        if ({c_w, c_idx, c_wrap, c_active} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_c: w=%h idx=%0d wrap=%b active=%b, want all 0", c_w, c_idx, c_wrap, c_active);
        end
        #1;
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    endtask

    task automatic test_direct();
        logic [7:0] exp_w [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        a_en = 1'b1; a_mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            a_x = 3'(i);
            @(posedge clk); #1;
            n_vec++;
            if (a_w !== exp_w[i] || a_idx !== 3'(i)) begin
                n_err++;
                $display("FAIL direct_x%0d: w=%h idx=%0d, want w=%h idx=%0d", i, a_w, a_idx, exp_w[i], i);
            end
            n_vec++;
            if (a_active !== 1'b1 || a_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL direct_flags_x%0d: active=%b wrap=%b, want 1 0", i, a_active, a_wrap);
            end
        end
    endtask

    task automatic test_scan_up_dwell1();
        logic [2:0] exp_idx [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
        logic [7:0] exp_w   [4] = '{8'h40, 8'h80, 8'h01, 8'h02};
        logic       exp_wr  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        a_mode = 2'd1; a_load = 1'b1; a_x = 3'd6;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a_load = 1'b0;
            n_vec++;
            if (a_idx !== exp_idx[i] || a_w !== exp_w[i] || a_wrap !== exp_wr[i]) begin
                n_err++;
                $display("FAIL scan_up_c%0d: idx=%0d w=%h wrap=%b, want idx=%0d w=%h wrap=%b",
                         i, a_idx, a_w, a_wrap, exp_idx[i], exp_w[i], exp_wr[i]);
            end
        end
    endtask

    task automatic test_scan_down_dwell3();
        logic [2:0] exp_idx [8] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7};
        logic [7:0] exp_w   [8] = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80};
        logic       exp_wr  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        b_en = 1'b1; b_mode = 2'd2; b_load = 1'b1; b_x = 3'd1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            b_load = 1'b0;
            n_vec++;
            if (b_idx !== exp_idx[i] || b_w !== exp_w[i] || b_wrap !== exp_wr[i]) begin
                n_err++;
                $display("FAIL scan_down_c%0d: idx=%0d w=%h wrap=%b, want idx=%0d w=%h wrap=%b",
                         i, b_idx, b_w, b_wrap, exp_idx[i], exp_w[i], exp_wr[i]);
            end
        end
    endtask

    task automatic test_hold_enable();
        logic [2:0] exp_idx [4] = '{3'd4, 3'd4, 3'd4, 3'd5};
        logic [7:0] exp_w   [4] = '{8'h10, 8'h10, 8'h10, 8'h20};
        b_mode = 2'd1; b_load = 1'b1; b_x = 3'd4;
        @(posedge clk); #1;
        b_load = 1'b0;
        @(posedge clk); #1;
        b_mode = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (b_w !== 8'h10 || b_idx !== 3'd4 || b_active !== 1'b1 || b_wrap !== 1'b0) begin
                n_err++;
                $display("FAIL hold_c%0d: w=%h idx=%0d active=%b wrap=%b, want w=10 idx=4 active=1 wrap=0",
                         i, b_w, b_idx, b_active, b_wrap);
            end
        end
        b_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (b_w !== 8'h00 || b_active !== 1'b0 || b_idx !== 3'd4) begin
                n_err++;
                $display("FAIL disabled_c%0d: w=%h active=%b idx=%0d, want w=00 active=0 idx=4",
                         i, b_w, b_active, b_idx);
            end
        end
        b_en = 1'b1; b_mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (b_idx !== exp_idx[i] || b_w !== exp_w[i] || b_active !== 1'b1) begin
                n_err++;
                $display("FAIL resume_c%0d: idx=%0d w=%h active=%b, want idx=%0d w=%h active=1",
                         i, b_idx, b_w, b_active, exp_idx[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        #3;
        n_vec++;
        if (b_idx !== 3'd5) begin
            n_err++;
            $display("FAIL pre_reset_idx: idx=%0d, want 5", b_idx);
        end
        b_rst_n = 1'b0;
        #1;
        n_vec++;
        if (b_w !== 8'h00 || b_idx !== 3'd0 || b_wrap !== 1'b0 || b_active !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: w=%h idx=%0d wrap=%b active=%b, want all 0",
                     b_w, b_idx, b_wrap, b_active);
        end
        #2;
        b_rst_n = 1'b1;
    endtask

    task automatic test_width_n4();
        logic [15:0] exp_w  [5] = '{16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h0002};
        logic        exp_wr [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        c_en = 1'b1; c_mode = 2'd1; c_load = 1'b1; c_x = 4'd15;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            c_load = 1'b0;
            n_vec++;
            if (c_w !== exp_w[i] || c_wrap !== exp_wr[i]) begin
                n_err++;
                $display("FAIL n4_scan_c%0d: w=%h wrap=%b, want w=%h wrap=%b",
                         i, c_w, c_wrap, exp_w[i], exp_wr[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_up_dwell1();
        test_scan_down_dwell3();
        test_hold_enable();
        test_async_reset();
        test_width_n4();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_onehot_decoder_seq
`default_nettype wire
